// File: rtl/sprite_linebuf_engine.sv
// sprite_linebuf_engine
//   Double-buffered sprite line buffer. While the front buffer is scanned out
//   (and cleared as it is read), sprite rows are drawn into the back buffer one
//   column per cycle. line_swap exchanges the buffers at the start of a line.
//
// Ports
//   master_clk  : clock, all logic on rising edge
//   reset       : synchronous active-high reset; starts a full clear of both buffers
//   pixel_ce    : scanout enable; pix_out <= front[rd_x], front[rd_x] <= 0
//   line_swap   : one-cycle pulse at line start, swaps buffers, aborts a draw
//   rd_x        : scanout address
//   pix_out     : scanout pixel {col,pix}, 1-cycle latency, holds between enables
//   cmd_valid/cmd_ready : sprite-row handshake
//   cmd_x, cmd_col, cmd_flip, cmd_planes : sprite row (plane p at [p*SPR_W +: SPR_W])
//   busy        : high while clearing or drawing
//   overrun     : one-cycle pulse when line_swap cuts a draw short
module sprite_linebuf_engine #(
    parameter int AW     = 9,
    parameter int LINE_W = 384,   // must not exceed 2**AW
    parameter int PW     = 4,
    parameter int CW     = 4,
    parameter int SPR_W  = 16
) (
    input  logic                  master_clk,
    input  logic                  reset,
    input  logic                  pixel_ce,
    input  logic                  line_swap,
    input  logic [AW-1:0]         rd_x,
    output logic [CW+PW-1:0]      pix_out,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [AW-1:0]         cmd_x,
    input  logic [CW-1:0]         cmd_col,
    input  logic                  cmd_flip,
    input  logic [PW*SPR_W-1:0]   cmd_planes,
    output logic                  busy,
    output logic                  overrun
);

    localparam int DW    = CW + PW;
    localparam int DEPTH = 1 << AW;
    localparam int IW    = (SPR_W > 1) ? $clog2(SPR_W) : 1;

    typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_DRAW} state_t;

    state_t               r_state;
    logic                 r_sel;        // 0: buf0 is front, 1: buf1 is front
    logic [AW-1:0]        r_clr_n;
    logic [IW-1:0]        r_i;
    logic [AW-1:0]        r_x;
    logic [CW-1:0]        r_col;
    logic                 r_flip;
    logic [PW*SPR_W-1:0]  r_planes;
    logic [DW-1:0]        r_pix_out;
    logic                 r_overrun;

    logic [DW-1:0]        r_buf0 [DEPTH];
    logic [DW-1:0]        r_buf1 [DEPTH];

    logic [IW-1:0]        w_src_c;
    logic [PW-1:0]        w_pix;
    logic [AW-1:0]        w_draw_addr;
    logic                 w_draw_we;
    logic                 w_scan_in_line;
    logic                 w_scan_clr;
    logic                 w_clr_we;
    logic                 w_last;
    logic [DW-1:0]        w_front_rd;

    assign w_src_c     = r_flip ? (IW'(SPR_W - 1) - r_i) : r_i;
    // Address arithmetic truncates to AW bits, which gives the wrap at 2**AW.
    assign w_draw_addr = r_x + AW'(r_i);
    assign w_last      = (r_i == IW'(SPR_W - 1));

    always_comb begin
        w_pix = '0;
        for (int p = 0; p < PW; p++)
            w_pix[p] = r_planes[p*SPR_W + int'(w_src_c)];
    end

    // Zero pixels are transparent; off-line addresses are clipped.
    assign w_draw_we      = !reset && (r_state == S_DRAW) && (w_pix != '0) &&
                            ({1'b0, w_draw_addr} < (AW+1)'(LINE_W));
    assign w_scan_in_line = ({1'b0, rd_x} < (AW+1)'(LINE_W));
    // The clear sweep owns both buffers, so scanout clears are suppressed then.
    assign w_scan_clr     = !reset && pixel_ce && (r_state != S_CLEAR) && w_scan_in_line;
    assign w_clr_we       = !reset && (r_state == S_CLEAR);
    assign w_front_rd     = r_sel ? r_buf1[rd_x] : r_buf0[rd_x];

    assign cmd_ready = !reset && (r_state == S_IDLE) && !line_swap;
    assign busy      = (r_state != S_IDLE);
    assign pix_out   = r_pix_out;
    assign overrun   = r_overrun;

    // Buffer storage. Scan clears hit the front, draws hit the back, so the
    // two write sources never collide on the same array entry.
    always_ff @(posedge master_clk) begin
        if (w_clr_we) begin
            r_buf0[r_clr_n] <= '0;
            r_buf1[r_clr_n] <= '0;
        end else begin
            if (w_scan_clr) begin
                if (r_sel) r_buf1[rd_x] <= '0;
                else       r_buf0[rd_x] <= '0;
            end
            if (w_draw_we) begin
                if (r_sel) r_buf0[w_draw_addr] <= {r_col, w_pix};
                else       r_buf1[w_draw_addr] <= {r_col, w_pix};
            end
        end
    end

    always_ff @(posedge master_clk) begin
        if (reset) begin
            r_state   <= S_CLEAR;
            r_clr_n   <= '0;
            r_sel     <= 1'b0;
            r_pix_out <= '0;
            r_overrun <= 1'b0;
            r_i       <= '0;
            r_x       <= '0;
            r_col     <= '0;
            r_flip    <= 1'b0;
            r_planes  <= '0;
        end else begin
            r_overrun <= 1'b0;
            if (line_swap)
                r_sel <= ~r_sel;
            // Reads the pre-toggle front even on a swap cycle.
            if (pixel_ce)
                r_pix_out <= w_scan_in_line ? w_front_rd : '0;

            case (r_state)
                S_CLEAR: begin
                    if (r_clr_n == AW'(LINE_W - 1))
                        r_state <= S_IDLE;
                    else
                        r_clr_n <= r_clr_n + 1'b1;
                end
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        r_x      <= cmd_x;
                        r_col    <= cmd_col;
                        r_flip   <= cmd_flip;
                        r_planes <= cmd_planes;
                        r_i      <= '0;
                        r_state  <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    // The column on the swap cycle still lands in the old back
                    // buffer; only the columns after it are dropped.
                    if (line_swap) begin
                        r_state   <= S_IDLE;
                        r_overrun <= 1'b1;
                    end else if (w_last) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_i <= r_i + 1'b1;
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: doc/sprite_linebuf_engine.md
SPRITE_LINEBUF_ENGINE -- requirements
Module: sprite_linebuf_engine

Interface
REQ-001 SHALL have parameter AW, default 9: line-buffer address width.
REQ-002 SHALL have parameter LINE_W, default 384: visible pixels per line, and LINE_W SHALL be no greater than 2^AW.
REQ-003 SHALL have parameter PW, default 4: bitplanes per pixel.
REQ-004 SHALL have parameter CW, default 4: colour-select bits per sprite.
REQ-005 SHALL have parameter SPR_W, default 16: pixels per sprite row.
REQ-006 SHALL have port master_clk  in  1: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-008 SHALL have port pixel_ce  in  1: scanout pixel enable.
REQ-009 SHALL have port line_swap  in  1: one-cycle pulse at line start.
REQ-010 SHALL have port rd_x  in  AW: scanout address.
REQ-011 SHALL have port pix_out  out  CW+PW: scanout pixel, formatted as {col,pix}.
REQ-012 SHALL have port cmd_valid  in  1, cmd_ready  out  1: sprite-row handshake.
REQ-013 SHALL have port cmd_x  in  AW: leftmost x of the sprite row.
REQ-014 SHALL have port cmd_col  in  CW: colour select.
REQ-015 SHALL have port cmd_flip  in  1: horizontal mirror.
REQ-016 SHALL have port cmd_planes  in  PW*SPR_W: plane p occupies bits [p*SPR_W +: SPR_W], and bit i of each plane belongs to pixel column i.
REQ-017 SHALL have port busy  out  1: high in CLEAR or DRAW.
REQ-018 SHALL have port overrun  out  1: one-cycle pulse when a draw is aborted.

Function
REQ-019 SHALL hold two line buffers of 2^AW x (CW+PW) bits; bank-select bit sel SHALL name the front (scanout) buffer, and the other buffer is the back (draw) buffer.
REQ-020 SHALL toggle sel on the cycle after line_swap is sampled high.
REQ-021 SHALL, on a cycle where pixel_ce and line_swap are both high, scan out from the pre-toggle front buffer.
REQ-022 SHALL implement write FSM states CLEAR, IDLE, DRAW.
REQ-023 SHALL drive cmd_ready = (state==IDLE) & !line_swap; a command SHALL be accepted on cmd_valid & cmd_ready.
REQ-024 SHALL, on accept, capture cmd_x, cmd_col, cmd_flip and cmd_planes, set column index i=0, and enter DRAW.
REQ-025 SHALL, in DRAW, process one column per cycle: source column c = cmd_flip ? SPR_W-1-i : i; pixel value p = {plane PW-1 bit c, ..., plane 0 bit c}; address a = (cmd_x + i) mod 2^AW.
REQ-026 SHALL write back[a] <= {col,p} only when p != 0 and a < LINE_W; p == 0 is transparent and SHALL leave the stored value unchanged.
REQ-027 SHALL give priority to the later-written sprite on overlap: a non-zero pixel overwrites.
REQ-028 SHALL return from DRAW to IDLE after the cycle in which i == SPR_W-1; SPR_W cycles per command, and the next accept SHALL occur no earlier than the following cycle.
REQ-029 SHALL wrap x at 2^AW: pixels with cmd_x+i >= 2^AW land at low addresses, subject to the a < LINE_W clip.
REQ-030 SHALL, on line_swap during DRAW, abort the remaining columns, go to IDLE, and pulse overrun high for exactly one cycle.
REQ-031 SHALL, on line_swap during IDLE, not pulse overrun.
REQ-032 SHALL, on pixel_ce, set pix_out <= (rd_x < LINE_W) ? front[rd_x] : 0, and SHALL write front[rd_x] <= 0 in the same cycle (clear-on-read); latency is 1 cycle and pix_out SHALL hold between enables.
REQ-033 SHALL allow scanout clears and DRAW writes in the same cycle; they never conflict because they target different buffers.

Reset
REQ-034 SHALL, while reset is high, force sel=0, pix_out=0, overrun=0, cmd_ready=0, state=CLEAR, clear counter=0.
REQ-035 SHALL, in CLEAR, zero address n of both buffers per cycle for n = 0..LINE_W-1, then enter IDLE (LINE_W cycles, busy=1).
REQ-036 SHALL, in CLEAR, ignore pixel_ce memory writes; pix_out SHALL still update and read 0 for already-cleared addresses.
REQ-037 SHALL still toggle sel on line_swap during CLEAR, without pulsing overrun and without restarting the clear.
REQ-038 SHALL, on reset asserted mid-DRAW, abandon the command with no further writes and no overrun pulse, and restart CLEAR.

Verification
REQ-039 SHALL be verified by: reset, then wait 384 cycles -> busy=0, cmd_ready=1; full-line scan returns pix_out=0 everywhere.
REQ-040 SHALL be verified by: cmd_x=10, col=5, flip=0, plane0=16'h0001, other planes 0, then swap and scan x=10 -> pix_out=8'h51; x=11..25 -> 8'h00; a second scan of x=10 after the next swap -> 8'h00 (cleared).
REQ-041 SHALL be verified by: same command with flip=1 -> pixel appears at x=25, not x=10.
REQ-042 SHALL be verified by: cmd_x=508 (AW=9), all planes 16'hFFFF, col=3 -> x=0..11 hold 8'h3F; x=508..511 are not written (>= LINE_W) and read 0.
REQ-043 SHALL be verified by: two overlapping sprites at x=100 with col=1 then col=2 -> x=100..115 read 8'h2F; a second sprite with zero planes leaves 8'h1F intact.
REQ-044 SHALL be verified by: line_swap 5 cycles after accept -> overrun pulses 1 cycle, only 5 pixels are written, cmd_ready is low on the swap cycle and high on the next cycle.
